// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared constants and encodings for the FP divider back end.
//   WIDTH/EXPW   : divider fraction width and signed biased exponent width
//   rm_e / cls_e : rounding-mode and operand-class encodings
//   QNAN/PINF/MAXF, FLAG_* : binary32 constants and flag bit positions
package fdiv_pkg;
    localparam int WIDTH   = 26;
    localparam int EXPW    = 10;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] MAXF = 32'h7F7FFFFF;

    // flags vector is {NV,DZ,OF,UF,NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_INF    = 3'd2,
        CLS_QNAN   = 3'd3,
        CLS_DZ     = 3'd4
    } cls_e;
endpackage

// File: rtl/fdiv_round_pack_if.sv
// fdiv_round_pack_if: quotient/sideband input channel and binary32 result
// output channel of the divider round/pack stage.
//   slave  : the round/pack stage
//   master : the producer/consumer side (divider and result sink)
//
// Handshake: a word moves across a channel on a clock edge where valid and
// ready are both high. Once valid is raised the sender holds valid and the
// payload stable until that edge; ready may change freely and never depends
// combinationally on the same channel's valid.
interface fdiv_round_pack_if;
    import fdiv_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] quot;
    logic             sticky;
    logic             sign;
    logic [EXPW-1:0]  exp_in;
    logic [2:0]       cls;
    logic [2:0]       rm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [4:0]       flags;

    modport slave (
        input  in_valid, quot, sticky, sign, exp_in, cls, rm, out_ready,
        output in_ready, out_valid, result, flags
    );

    modport master (
        output in_valid, quot, sticky, sign, exp_in, cls, rm, out_ready,
        input  in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fdiv_round_incr.sv
// fdiv_round_incr: combinational rounding decision.
//   rm   : rounding mode (values 5-7 behave as RNE)
//   sign : result sign
//   lsb  : least significant kept bit of the significand
//   g, s : guard bit and sticky bit below it
//   inc  : add one ulp to the significand
//   nx   : discarded bits were nonzero (inexact)
module fdiv_round_incr
    import fdiv_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    output logic       inc,
    output logic       nx
);
    always_comb begin
        nx = g | s;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = !sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = g & (s | lsb);
        endcase
    end
endmodule

// File: rtl/fdiv_round_pack.sv
// fdiv_round_pack: normalize, round and pack the divider quotient into an
// IEEE-754 binary32 result with {NV,DZ,OF,UF,NX} flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : input channel (quot, sticky, sign, exp_in, cls, rm) and
//              output channel (result, flags), valid/ready on both
// Two registered stages: stage 1 normalizes, stage 2 rounds and packs.
module fdiv_round_pack
    import fdiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fdiv_round_pack_if.slave  bus
);
    localparam logic [EXPW:0] E_ONE = {{EXPW{1'b0}}, 1'b1};

    logic v1, v2, ld1, ld2;

    // Each stage loads when it is empty or its contents move on this edge.
    assign ld2          = !v2 || bus.out_ready;
    assign ld1          = !v1 || ld2;
    assign bus.in_ready = ld1;
    assign bus.out_valid = v2;

    // ---------------- stage 1: normalize ----------------
    logic [EXPW:0] exp_ext;
    logic [23:0]   n_sig;
    logic          n_g;
    logic [EXPW:0] n_e;

    assign exp_ext = {bus.exp_in[EXPW-1], bus.exp_in};

    // Quotient in [0.5,1): if the 2^-1 bit is clear, the value is one bit
    // short and the exponent drops by one; no guard bit is available then.
    always_comb begin
        if (bus.quot[WIDTH-2]) begin
            n_sig = bus.quot[WIDTH-2:1];
            n_g   = bus.quot[0];
            n_e   = exp_ext;
        end else begin
            n_sig = bus.quot[WIDTH-3:0];
            n_g   = 1'b0;
            n_e   = exp_ext - E_ONE;
        end
    end

    logic [23:0]   s1_sig;
    logic          s1_g, s1_s, s1_sign;
    logic [EXPW:0] s1_e;
    logic [2:0]    s1_cls, s1_rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sig  <= '0;
            s1_g    <= 1'b0;
            s1_s    <= 1'b0;
            s1_sign <= 1'b0;
            s1_e    <= '0;
            s1_cls  <= '0;
            s1_rm   <= '0;
        end else if (ld1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sig  <= n_sig;
                s1_g    <= n_g;
                s1_s    <= bus.sticky;
                s1_sign <= bus.sign;
                s1_e    <= n_e;
                s1_cls  <= bus.cls;
                s1_rm   <= bus.rm;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic          inc, nx;
    logic [24:0]   sum;
    logic [23:0]   r_sig;
    logic [EXPW:0] r_e;
    logic          ovf, unf, ovf_inf;
    logic [31:0]   r_res;
    logic [4:0]    r_flg;

    fdiv_round_incr u_incr (
        .rm   (s1_rm),
        .sign (s1_sign),
        .lsb  (s1_sig[0]),
        .g    (s1_g),
        .s    (s1_s),
        .inc  (inc),
        .nx   (nx)
    );

    always_comb begin
        sum = {1'b0, s1_sig} + {24'b0, inc};
        // A carry out can only produce 1.000..0, so shifting right loses nothing.
        if (sum[24]) begin
            r_sig = sum[24:1];
            r_e   = s1_e + E_ONE;
        end else begin
            r_sig = sum[23:0];
            r_e   = s1_e;
        end
        ovf = !r_e[EXPW] && (r_e[EXPW-1:0] >= EXPW'(EXP_MAX));
        unf = r_e[EXPW] || (r_e == '0);

        // Overflow saturates to max finite when the mode rounds toward zero
        // for this sign; otherwise it goes to infinity.
        case (s1_rm)
            RM_RTZ:  ovf_inf = 1'b0;
            RM_RDN:  ovf_inf = s1_sign;
            RM_RUP:  ovf_inf = !s1_sign;
            default: ovf_inf = 1'b1;
        endcase

        r_res = 32'b0;
        r_flg = 5'b0;
        case (s1_cls)
            CLS_NORMAL: begin
                if (ovf) begin
                    r_res = (ovf_inf ? PINF : MAXF) | {s1_sign, 31'b0};
                    r_flg[FLAG_OF] = 1'b1;
                    r_flg[FLAG_NX] = 1'b1;
                end else if (unf) begin
                    r_res = {s1_sign, 31'b0};
                    r_flg[FLAG_UF] = 1'b1;
                    r_flg[FLAG_NX] = 1'b1;
                end else begin
                    r_res = {s1_sign, r_e[7:0], r_sig[22:0]};
                    r_flg[FLAG_NX] = nx;
                end
            end
            CLS_ZERO: r_res = {s1_sign, 31'b0};
            CLS_INF:  r_res = PINF | {s1_sign, 31'b0};
            CLS_DZ: begin
                r_res = PINF | {s1_sign, 31'b0};
                r_flg[FLAG_DZ] = 1'b1;
            end
            default: begin
                r_res = QNAN;
                r_flg[FLAG_NV] = 1'b1;
            end
        endcase
    end

    logic [31:0] result_q;
    logic [4:0]  flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                result_q <= r_res;
                flags_q  <= r_flg;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;

    // The quotient's 2^0 bit is never set for an in-range quotient, and the
    // hidden bit is implied by the packed format.
    logic unused_bits;
    assign unused_bits = ^{bus.quot[WIDTH-1], r_sig[23]};
endmodule

// File: tb/tb_fdiv_round_pack.sv
// tb_fdiv_round_pack: directed-vector bench for fdiv_round_pack with an
// expected-result queue, backpressure, mid-flight reset and random-ready replay.
module tb_fdiv_round_pack;
    import fdiv_pkg::*;

    typedef struct packed {
        logic [25:0] q;
        logic        st;
        logic        sg;
        logic [9:0]  e;
        logic [2:0]  c;
        logic [2:0]  r;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    localparam int NVEC = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ready_mode = 1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [36:0] exp_q[$];
    vec_t vecs[NVEC];

    fdiv_round_pack_if bus ();

    fdiv_round_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / ready generation ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: a transfer happens on the next rising edge whenever
    // out_valid & out_ready are seen high at the falling edge.
    always @(negedge clk) begin : mon
        logic [36:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e[36:5]);
                check("flags", 32'(bus.flags), 32'(e[4:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic vec_t mk(logic [25:0] q, logic st, logic sg, logic [9:0] e,
                                logic [2:0] c, logic [2:0] r, logic [31:0] res, logic [4:0] fl);
        vec_t v;
        v.q = q; v.st = st; v.sg = sg; v.e = e; v.c = c; v.r = r; v.res = res; v.fl = fl;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.quot   = v.q;
        bus.sticky = v.st;
        bus.sign   = v.sg;
        bus.exp_in = v.e;
        bus.cls    = v.c;
        bus.rm     = v.r;
    endtask

    task automatic send(input vec_t v);
        bit acc = 1'b0;
        drive(v);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            exp_q.push_back({v.res, v.fl});
            @(posedge clk);
            #1;
        end else begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.quot     = 26'($urandom);
        bus.sticky   = 1'($urandom);
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0]  = mk(26'h1000000, 0, 0, 10'd127, CLS_NORMAL, RM_RNE, 32'h3F800000, 5'h00);
        vecs[1]  = mk(26'h1FFFFFF, 1, 0, 10'd127, CLS_NORMAL, RM_RNE, 32'h40000000, 5'h01);
        vecs[2]  = mk(26'h1FFFFFF, 1, 0, 10'd127, CLS_NORMAL, RM_RTZ, 32'h3FFFFFFF, 5'h01);
        vecs[3]  = mk(26'h1000000, 0, 1, 10'd300, CLS_NORMAL, RM_RDN, 32'hFF800000, 5'h05);
        vecs[4]  = mk(26'h1000000, 0, 1, 10'd300, CLS_NORMAL, RM_RUP, 32'hFF7FFFFF, 5'h05);
        vecs[5]  = mk(26'h1000000, 0, 1, 10'h3FB, CLS_NORMAL, RM_RNE, 32'h80000000, 5'h03);
        vecs[6]  = mk(26'h1000000, 0, 1, 10'd127, CLS_DZ,     RM_RNE, 32'hFF800000, 5'h08);
        vecs[7]  = mk(26'h1000000, 0, 0, 10'd127, CLS_QNAN,   RM_RNE, 32'h7FC00000, 5'h10);
        vecs[8]  = mk(26'h1000000, 0, 1, 10'd127, CLS_ZERO,   RM_RNE, 32'h80000000, 5'h00);
        vecs[9]  = mk(26'h0C00000, 0, 0, 10'd130, CLS_NORMAL, RM_RNE, 32'h40C00000, 5'h00);
        vecs[10] = mk(26'h1000001, 0, 0, 10'd127, CLS_NORMAL, RM_RNE, 32'h3F800000, 5'h01);
        vecs[11] = mk(26'h1000003, 0, 0, 10'd127, CLS_NORMAL, RM_RNE, 32'h3F800002, 5'h01);
        vecs[12] = mk(26'h1000001, 0, 0, 10'd127, CLS_NORMAL, RM_RMM, 32'h3F800001, 5'h01);
        vecs[13] = mk(26'h1000000, 1, 1, 10'd127, CLS_NORMAL, RM_RDN, 32'hBF800001, 5'h01);
        vecs[14] = mk(26'h1FFFFFF, 1, 0, 10'd254, CLS_NORMAL, RM_RNE, 32'h7F800000, 5'h05);
        vecs[15] = mk(26'h1000000, 0, 0, 10'd254, CLS_NORMAL, RM_RNE, 32'h7F000000, 5'h00);
        vecs[16] = mk(26'h0800000, 0, 0, 10'd1,   CLS_NORMAL, RM_RNE, 32'h00000000, 5'h03);
        vecs[17] = mk(26'h1000000, 0, 0, 10'd1,   CLS_NORMAL, RM_RNE, 32'h00800000, 5'h00);
        vecs[18] = mk(26'h1000000, 0, 0, 10'd300, CLS_NORMAL, 3'd7,   32'h7F800000, 5'h05);
        vecs[19] = mk(26'h1000000, 0, 0, 10'd300, CLS_NORMAL, RM_RTZ, 32'h7F7FFFFF, 5'h05);
        vecs[20] = mk(26'h1000000, 0, 0, 10'd127, 3'd6,       RM_RNE, 32'h7FC00000, 5'h10);
        vecs[21] = mk(26'h1000000, 0, 1, 10'd127, CLS_INF,    RM_RNE, 32'hFF800000, 5'h00);
        vecs[22] = mk(26'h1000000, 1, 0, 10'd127, CLS_NORMAL, RM_RUP, 32'h3F800001, 5'h01);
        vecs[23] = mk(26'h0800001, 0, 0, 10'd127, CLS_NORMAL, RM_RNE, 32'h3F000001, 5'h00);

        bus.in_valid = 1'b0;
        drive(vecs[0]);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // latency: accept edge, then one more edge before out_valid
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        exp_q.push_back({vecs[0].res, vecs[0].fl});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("lat_cycle1", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2", 32'(bus.out_valid), 32'd1);
        drain();

        // all directed vectors back to back, consumer always ready
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        drain();

        // backpressure: two fill the pipe, the third must wait
        set_ready(0);
        send(vecs[1]);
        send(vecs[2]);
        drive(vecs[3]);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_result", bus.result, exp_q[0][36:5]);
        end
        ready_mode = 1;
        @(posedge clk);
        #1;
        send(vecs[3]);
        drain();

        // reset with both stages full
        set_ready(0);
        send(vecs[4]);
        send(vecs[5]);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_flags", 32'(bus.flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ready(1);
        send(vecs[9]);
        drain();

        // random consumer readiness and input gaps
        ready_mode = 2;
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < NVEC; i++) begin
                send(vecs[i]);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        ready_mode = 1;
        drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
